// File: rtl/mau_pkg.sv
// Shared opcode, FSM state and access-size encodings for the memory access unit.
package mau_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Index of the last byte of an access (byte count minus one).
    function automatic logic [1:0] size_last(input size_t sz);
        case (sz)
            SZ_H:    return 2'd1;
            SZ_W:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mau_decode.sv
// Combinational load/store opcode decode: size, sign, direction, illegal and misaligned flags.
module mau_decode
    import mau_pkg::*;
(
    input  logic [5:0] opc,
    input  logic       rw,
    input  logic [1:0] addr_lo,
    output size_t      size,
    output logic       sgn,
    output logic       store,
    output logic       illegal,
    output logic       misaligned
);

    always_comb begin
        size    = SZ_B;
        sgn     = 1'b0;
        store   = 1'b0;
        illegal = 1'b0;
        case (opc)
            OP_LB:  sgn = 1'b1;
            OP_LH:  begin size = SZ_H; sgn = 1'b1; end
            OP_LW:  size = SZ_W;
            OP_LBU: sgn = 1'b0;
            OP_LHU: size = SZ_H;
            OP_SB:  store = 1'b1;
            OP_SH:  begin size = SZ_H; store = 1'b1; end
            OP_SW:  begin size = SZ_W; store = 1'b1; end
            default: illegal = 1'b1;
        endcase
        // rw = 1 means load, so a store opcode paired with rw = 1 (or vice versa) is rejected.
        if (store == rw) begin
            illegal = 1'b1;
        end
        misaligned = ((size == SZ_H) && addr_lo[0]) ||
                     ((size == SZ_W) && (addr_lo != 2'b00));
    end

endmodule

// File: rtl/mem_access_unit.sv
// Word load/store to byte-RAM bridge, big-endian, 1/2/4-byte sequencing; MAU_TIMEOUT_EN adds a per-byte ack timeout.
// Zero-wait latency accept->moc is n+1 cycles; each byte stalls on mem_ack, and a held mov parks in RELEASE.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mov,
    input  logic              rw,
    input  logic [5:0]        opc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              moc,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;
    size_t             size_q;
    logic              sgn_q;
    logic              load_q;
    logic              err_q;
    logic [1:0]        k_q;

    size_t             dec_size;
    logic              dec_sgn;
    logic              dec_store;
    logic              dec_illegal;
    logic              dec_misaligned;
    logic              last_byte;
    logic [1:0]        wbyte_idx;
    logic              tmo;

    mau_decode u_decode (
        .opc        (opc),
        .rw         (rw),
        .addr_lo    (addr[1:0]),
        .size       (dec_size),
        .sgn        (dec_sgn),
        .store      (dec_store),
        .illegal    (dec_illegal),
        .misaligned (dec_misaligned)
    );

    assign last_byte = (k_q == size_last(size_q));
    assign wbyte_idx = size_last(size_q) - k_q;

`ifdef MAU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts consecutive un-acked cycles of the byte currently being issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if ((state != ST_ISSUE) || mem_ack) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo = (state == ST_ISSUE) && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    // Without the timeout feature ISSUE waits for mem_ack indefinitely.
    assign tmo = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        moc       = 1'b0;
        err       = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (mov) begin
                    state_nxt = (dec_illegal || dec_misaligned) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = !load_q;
                mem_addr  = base_q + ADDR_W'(k_q);
                mem_wdata = wdata_q[{wbyte_idx, 3'b000} +: 8];
                if (tmo || (mem_ack && last_byte)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                moc       = 1'b1;
                err       = err_q;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!mov) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            base_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            size_q  <= SZ_B;
            sgn_q   <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mov) begin
                        base_q  <= addr;
                        wdata_q <= wdata;
                        size_q  <= dec_size;
                        sgn_q   <= dec_sgn;
                        load_q  <= rw;
                        err_q   <= dec_illegal || dec_misaligned;
                        acc_q   <= '0;
                        k_q     <= 2'd0;
                    end
                end
                ST_ISSUE: begin
                    if (tmo) begin
                        err_q <= 1'b1;
                    end else if (mem_ack) begin
                        if (load_q) begin
                            acc_q <= {acc_q[23:0], mem_rdata};
                        end
                        k_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result is hidden while a transfer is in flight, so it reads as cleared from accept until DONE.
    always_comb begin
        rdata = '0;
        if ((state != ST_ISSUE) && load_q && !err_q) begin
            case (size_q)
                SZ_B:    rdata = {{24{sgn_q & acc_q[7]}}, acc_q[7:0]};
                SZ_H:    rdata = {{16{sgn_q & acc_q[15]}}, acc_q[15:0]};
                default: rdata = acc_q;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Bridges the DataPath's word-oriented load/store handshake (MOV/MOC, RW, opcode) to the byte-wide 512-byte RAM.
- Decodes the MIPS load/store opcode.
- Checks alignment.
- Sequences 1/2/4 byte accesses big-endian.
- Assembles and sign- or zero-extends load data, then completes with a one-cycle MOC pulse.
- Sits directly downstream of DataPath and directly upstream of the RAM.

Parameters:
ADDR_W, 9, byte address width (512-byte RAM)
TIMEOUT, 16, max cycles waiting for mem_ack per byte (used only with MAU_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
mov  in  1  DataPath request valid; held high until moc seen
rw  in  1  1 = load, 0 = store
opc  in  6  MIPS opcode (LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011)
addr  in  ADDR_W  byte address from MAR
wdata  in  32  store data
rdata  out  32  extended load result
moc  out  1  one-cycle completion pulse
err  out  1  valid with moc: misaligned, illegal opc, or timeout
mem_en  out  1  byte access strobe
mem_we  out  1  1 = byte write
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, valid when mem_ack = 1
mem_ack  in  1  byte access complete (may be same cycle as mem_en)

Behaviour:
- Reset values: state IDLE; rdata = 0, moc = 0, err = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. Reset mid-transfer aborts with no moc; partially written bytes are not rolled back.
- States:
  - IDLE, ISSUE, DONE, RELEASE.
- IDLE:
  - On mov = 1, latch addr, opc, wdata, rw; clear rdata.
  - Byte count n = 1/2/4 from opc.
  - If opc is not in the table, or rw disagrees with opc class (loads 100xxx, stores 101xxx), set err_pending. Also set err_pending if misaligned: halfword with addr[0] ≠ 0, or word with addr[1:0] ≠ 0.
  - With err_pending, go to DONE; no memory access occurs. Otherwise go to ISSUE with index k = 0.
- ISSUE:
  - mem_en = 1, mem_addr = base + k, mem_we = !rw.
  - mem_wdata = wdata byte (n-1-k) of its low n bytes (big-endian: first byte is most significant).
  - Outputs stay stable until mem_ack = 1.
  - On ack: for loads, shift mem_rdata into the accumulator at the LSB. Then k++. When k = n-1 is acked, go to DONE with mem_en dropping the next cycle.
  - Base + k never wraps, because accesses are aligned (max word base 508).
- DONE:
  - moc = 1 for exactly one cycle; err = err_pending.
  - rdata is driven for loads:
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
    - LW as assembled.
  - On error, or for stores, rdata = 0.
  - rdata holds until the next accepted request.
  - Next state is RELEASE.
- RELEASE:
  - Wait until mov = 0, then go to IDLE. This prevents re-triggering on a held MOV.
  - mov = 0 in the DONE cycle itself goes straight to IDLE via RELEASE in 1 cycle.
- Latency with zero-wait RAM (ack same cycle): accept at cycle T, bytes at T+1..T+n, moc at T+n+1. Each wait state adds 1 cycle.
- mov dropped mid-transfer is ignored; the transfer completes.

Optional Feature:
MAU_TIMEOUT_EN:
- Defined: a counter clears on each byte issue and increments each ISSUE cycle without mem_ack. At TIMEOUT, abort to DONE with err = 1, rdata = 0, mem_en = 0.
- Undefined: no counter; ISSUE waits indefinitely for mem_ack.

Decomposition:
- Shared package mau_pkg:
  - Opcode localparams (OP_LB…OP_SW).
  - State encoding (2-bit IDLE/ISSUE/DONE/RELEASE).
  - Size encoding (SZ_B/SZ_H/SZ_W).
- One natural sub-module, mau_decode: combinational opc/rw/addr → size, signed, store, illegal, misaligned. It is reused by the bench scoreboard.

Test Plan:
- Preload RAM[0..3] = 8'h80,12,34,56; LW addr 0, zero-wait → rdata 32'h80123456, err = 0, moc 5 cycles after accept.
- LB addr 0 → rdata 32'hFFFFFF80. LBU addr 0 → 32'h00000080. LH addr 2 → 32'h00003456.
- SW addr 8, wdata 32'hDEADBEEF → RAM[8..11] = DE,AD,BE,EF. SB addr 13, wdata 32'h000000A5 → only RAM[13] = A5.
- LW addr 6 (misaligned) and opc 000000 → moc after 1 cycle in IDLE→DONE, err = 1, mem_en never asserted, rdata 0.
- RAM inserting 2 wait cycles per byte on LH addr 4 → moc 7 cycles after accept. Holding mov high 3 cycles after moc → no second transfer.
- Assert reset = 0 during byte 2 of SW addr 16 → next cycle mem_en = 0, moc = 0, state IDLE. With MAU_TIMEOUT_EN, a RAM that never acks → err = 1 and moc after TIMEOUT cycles.
